// File: rtl/hamming_pkg.sv
// Hamming(15,11) shared definitions: widths, bit-position maps and the
// reference encode/syndrome functions used by both encoder and decoder.
package hamming_pkg;

   localparam int HAM_DATA_W = 11;
   localparam int HAM_CODE_W = 15;
   localparam int HAM_PAR_W  = 4;

   localparam int HAM_PAR_IDX [HAM_PAR_W] = '{0, 1, 3, 7};
   localparam int HAM_DATA_IDX [HAM_DATA_W] =
      '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

   typedef logic [HAM_DATA_W-1:0] ham_data_t;
   typedef logic [HAM_CODE_W-1:0] ham_code_t;
   typedef logic [HAM_PAR_W-1:0]  ham_syn_t;

   // Index i is Hamming position i+1; parity k covers positions with bit k set.
   function automatic ham_code_t ham_encode(input ham_data_t d);
      ham_code_t c;
      logic      p;
      c = '0;
      for (int i = 0; i < HAM_DATA_W; i++)
         c[4'(HAM_DATA_IDX[i])] = d[4'(i)];
      for (int k = 0; k < HAM_PAR_W; k++) begin
         p = 1'b0;
         for (int j = 0; j < HAM_CODE_W; j++)
            if ((((j + 1) >> k) & 1) == 1)
               p = p ^ c[4'(j)];
         c[4'(HAM_PAR_IDX[k])] = p;
      end
      return c;
   endfunction

   function automatic ham_syn_t ham_syndrome(input ham_code_t c);
      ham_syn_t s;
      s = '0;
      for (int j = 0; j < HAM_CODE_W; j++)
         if (c[4'(j)])
            s = s ^ 4'(j + 1);
      return s;
   endfunction

endpackage

// File: rtl/hamming_enc_stream_if.sv
// Valid/ready bundle for the encoder: 11-bit data in, 15-bit codeword out.
// master drives data and downstream ready; slave is the encoder side.
interface hamming_enc_stream_if;
   import hamming_pkg::*;

   logic      in_valid;
   logic      in_ready;
   ham_data_t in_data;
   logic      out_valid;
   logic      out_ready;
   ham_code_t out_code;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_code
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_code
   );

endinterface

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(15,11) encoder in the decoder's bit layout.
module hamming_enc_core
   import hamming_pkg::*;
(
   input  ham_data_t data,
   output ham_code_t code
);

   assign code = ham_encode(data);

endmodule

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(15,11) encoder with a 2-entry output FIFO.
// Optional single-bit error injection under HAMMING_ERR_INJECT_EN.
module hamming_enc_stream
   import hamming_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   hamming_enc_stream_if.slave bus,
`ifdef HAMMING_ERR_INJECT_EN
   input  logic             inj_en,
   input  logic [3:0]       inj_pos,
`endif
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   ham_code_t  enc_code;
   ham_code_t  wr_code;
   ham_code_t  head_q;
   ham_code_t  tail_q;
   logic [1:0] count_q;
   logic       push;
   logic       pop;

   hamming_enc_core u_core (
      .data (bus.in_data),
      .code (enc_code)
   );

`ifdef HAMMING_ERR_INJECT_EN
   ham_code_t flip;

   always_comb begin
      flip = '0;
      if (inj_en && inj_pos != 4'hF)
         flip[inj_pos] = 1'b1;
   end

   assign wr_code = enc_code ^ flip;
`else
   assign wr_code = enc_code;
`endif

   // Handshake flags come only from registered count.
   assign bus.in_ready  = (count_q != FULL);
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_code  = head_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         head_q   <= '0;
         tail_q   <= '0;
         word_cnt <= '0;
      end else begin
         if (pop)
            word_cnt <= word_cnt + CNT_W'(1);
         unique case (1'b1)
            // Push+pop only occurs at count 1: new word replaces head.
            (push && pop): begin
               head_q <= wr_code;
            end
            (push && !pop): begin
               if (count_q == 2'd0)
                  head_q <= wr_code;
               else
                  tail_q <= wr_code;
               count_q <= count_q + 2'd1;
            end
            (!push && pop): begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
